// File: rtl/furv_dbus.sv
// furv_dbus -- data-bus slave for the furv core.
//
// Purpose: serves the core's load/store port. Requests are latched in IDLE,
// optionally delayed by WAIT_STATES cycles, committed on the edge entering
// ACK and acknowledged with a single-cycle pulse. Behind the bus sit a
// word-organised RAM with byte-lane writes and a 4-word MMIO window
// (cycle counter, GPIO out, GPIO in, reserved). Unmapped accesses are still
// acknowledged, read as zero, drop their writes and set a sticky fault flag.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   mem        in   1  request valid, held until ack
//   mem_write  in   1  1 = store, 0 = load
//   addr       in  30  word address
//   sel        in   4  byte-lane enables (bit i -> wdata[8i+7:8i])
//   wdata      in  32  store data
//   rdata      out 32  read word, meaningful while ack = 1
//   ack        out  1  single-cycle completion pulse
//   gpio_out   out 32  MMIO output register
//   gpio_in    in  32  MMIO input, sampled at the commit edge
//   fault      out  1  sticky flag, set by any unmapped access

module furv_dbus #(
   parameter int          RAM_WORDS   = 1024,
   parameter int          WAIT_STATES = 0,
   parameter logic [29:0] MMIO_BASE   = 30'h3FFF_FC00,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem,
   input  logic        mem_write,
   input  logic [29:0] addr,
   input  logic [3:0]  sel,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic [31:0] gpio_out,
   input  logic [31:0] gpio_in,
   output logic        fault
);

   localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [3:0]  r_wait_cnt;
   logic [3:0]  w_wait_cnt_next;
   logic        w_commit;

   // Latched request
   logic [29:0] r_addr;
   logic [3:0]  r_sel;
   logic [31:0] r_wdata;
   logic        r_write;

   // Request seen by the commit logic
   logic [29:0] w_addr;
   logic [3:0]  w_sel;
   logic [31:0] w_wdata;
   logic        w_write;

   logic        w_is_ram;
   logic        w_is_mmio;
   logic [AW-1:0] w_idx;

   logic [31:0] r_ram [RAM_WORDS];
   logic [31:0] r_ram_q;
   logic [31:0] r_mmio_q;
   logic [31:0] w_mmio_rd;
   logic        r_rd_ram;
   logic [31:0] r_cycle;
   logic [31:0] r_gpio_out;
   logic [31:0] w_gpio_next;
   logic        w_gpio_we;
   logic        r_fault;

   // RAM image at elaboration: zeros.
   initial begin
      for (int i = 0; i < RAM_WORDS; i++) begin
         r_ram[i] = '0;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_cnt_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_wait_cnt_next = r_wait_cnt;
      w_commit        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mem) begin
               if (WAIT_STATES == 0) begin
                  w_state_next = S_ACK;
                  w_commit     = 1'b1;
               end else begin
                  w_state_next    = S_WAIT;
                  w_wait_cnt_next = WAIT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (r_wait_cnt == 4'd0) begin
               w_state_next = S_ACK;
               w_commit     = 1'b1;
            end else begin
               w_wait_cnt_next = r_wait_cnt - 4'd1;
            end
         end
         S_ACK: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      // Reset overrides everything: nothing commits, nothing is latched.
      if (rst) begin
         w_state_next = S_IDLE;
         w_commit     = 1'b0;
      end
   end

   // Reset is synchronous, but ack must already be low in the reset cycle.
   assign ack = (r_state == S_ACK) && !rst;

   // ------------------------------------------------------ request latch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_sel   <= '0;
         r_wdata <= '0;
         r_write <= 1'b0;
      end else if (r_state == S_IDLE && mem) begin
         r_addr  <= addr;
         r_sel   <= sel;
         r_wdata <= wdata;
         r_write <= mem_write;
      end
   end

   // With no wait states the commit edge is the latch edge, so the live
   // request is used; otherwise only the latched copy is (mem may drop).
   assign w_addr  = (r_state == S_IDLE) ? addr      : r_addr;
   assign w_sel   = (r_state == S_IDLE) ? sel       : r_sel;
   assign w_wdata = (r_state == S_IDLE) ? wdata     : r_wdata;
   assign w_write = (r_state == S_IDLE) ? mem_write : r_write;

   // ------------------------------------------------------------ decode
   assign w_is_ram  = ({2'b00, w_addr} < 32'(RAM_WORDS));
   assign w_is_mmio = !w_is_ram && (w_addr[29:2] == MMIO_BASE[29:2]);
   assign w_idx     = w_addr[AW-1:0];

   // --------------------------------------------------------------- RAM
   always_ff @(posedge clk) begin
      if (w_commit && w_is_ram) begin
         if (w_write) begin
            for (int i = 0; i < 4; i++) begin
               if (w_sel[i]) begin
                  r_ram[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
               end
            end
         end
         r_ram_q <= r_ram[w_idx];
      end
   end

   // -------------------------------------------------------------- MMIO
   always_comb begin
      w_mmio_rd = '0;
      case (w_addr[1:0])
         2'd0:    w_mmio_rd = r_cycle;
         2'd1:    w_mmio_rd = r_gpio_out;
         2'd2:    w_mmio_rd = gpio_in;
         default: w_mmio_rd = '0;
      endcase
   end

   assign w_gpio_we = w_commit && w_is_mmio && w_write && (w_addr[1:0] == 2'd1);

   for (genvar gi = 0; gi < 4; gi++) begin : g_gpio_lane
      assign w_gpio_next[8*gi +: 8] = (w_gpio_we && w_sel[gi]) ? w_wdata[8*gi +: 8]
                                                                : r_gpio_out[8*gi +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cycle    <= '0;
         r_gpio_out <= '0;
         r_mmio_q   <= '0;
         r_rd_ram   <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_cycle    <= r_cycle + 32'd1;
         r_gpio_out <= w_gpio_next;
         if (w_commit) begin
            r_rd_ram <= w_is_ram;
            // Unmapped reads return zero via this path.
            r_mmio_q <= w_is_mmio ? w_mmio_rd : 32'd0;
            if (!w_is_ram && !w_is_mmio) begin
               r_fault <= 1'b1;
            end
         end
      end
   end

   assign rdata    = r_rd_ram ? r_ram_q : r_mmio_q;
   assign gpio_out = r_gpio_out;
   assign fault    = r_fault;

endmodule

// File: tb/tb_furv_dbus.sv
// Testbench for furv_dbus. Three instances share one clock:
// index 0 has WAIT_STATES=0, index 1 has 3, index 2 has 2.
module tb_furv_dbus;

   logic        clk;
   logic        rst_a     [3];
   logic        mem_a     [3];
   logic        we_a      [3];
   logic [29:0] addr_a    [3];
   logic [3:0]  sel_a     [3];
   logic [31:0] wdata_a   [3];
   logic [31:0] rdata_a   [3];
   logic        ack_a     [3];
   logic [31:0] gpio_a    [3];
   logic        fault_a   [3];
   logic [31:0] gpio_in;

   int n_tests = 0;
   int n_fail  = 0;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      furv_dbus #(
         .RAM_WORDS  (1024),
         .WAIT_STATES((gi == 0) ? 0 : (gi == 1) ? 3 : 2),
         .MMIO_BASE  (30'h3FFF_FC00),
         .INIT_FILE  ("")
      ) u_dut (
         .clk      (clk),
         .rst      (rst_a[gi]),
         .mem      (mem_a[gi]),
         .mem_write(we_a[gi]),
         .addr     (addr_a[gi]),
         .sel      (sel_a[gi]),
         .wdata    (wdata_a[gi]),
         .rdata    (rdata_a[gi]),
         .ack      (ack_a[gi]),
         .gpio_out (gpio_a[gi]),
         .gpio_in  (gpio_in),
         .fault    (fault_a[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // One complete transaction. Called #1 after a rising edge; the request is
   // visible in the current cycle. Returns #1 after the rising edge that
   // follows the idle cycle after ack.
   task automatic access(input int d, input int ws, input bit wr, input logic [29:0] a,
                         input logic [3:0] s, input logic [31:0] wd,
                         output logic [31:0] rd, output logic [31:0] gp, output logic ft);
      int lat;
      bit got;
      mem_a[d] = 1'b1; we_a[d] = wr; addr_a[d] = a; sel_a[d] = s; wdata_a[d] = wd;
      lat = 0; got = 1'b0; rd = '0; gp = '0; ft = 1'b0;
      while (!got && lat < 40) begin
         @(negedge clk);
         if (ack_a[d]) begin
            got = 1'b1; rd = rdata_a[d]; gp = gpio_a[d]; ft = fault_a[d];
         end else begin
            lat++;
         end
      end
      chk($sformatf("dut%0d latency addr=%h", d, a), 32'(lat), 32'(1 + ws));
      @(posedge clk); #1;
      mem_a[d] = 1'b0;
      @(negedge clk);
      chk($sformatf("dut%0d ack single-cycle addr=%h", d, a), 32'(ack_a[d]), 32'd0);
      @(posedge clk); #1;
      $display("[TB] dut%0d %s addr=%h sel=%h wdata=%h rdata=%h lat=%0d",
               d, wr ? "st" : "ld", a, s, wd, rd, lat);
   endtask

   typedef struct {
      bit          wr;
      logic [29:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] gin;
      logic [31:0] exp_rd;
      logic [31:0] exp_gpio;
      bit          exp_fault;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   initial begin
      logic [31:0] rd, gp, c1, c2, c3;
      logic        ft;

      //            wr  addr            sel     wdata          gin           exp_rd        exp_gpio      fault
      vecs[0]  = '{1'b0, 30'h3FFF_FC00, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b1, 30'h0000_0004, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b0, 30'h0000_0004, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vecs[3]  = '{1'b1, 30'h0000_0004, 4'h4, 32'h1111_1111, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[4]  = '{1'b0, 30'h0000_0004, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'hDE11_BEEF, 32'h0000_0000, 1'b0};
      vecs[5]  = '{1'b1, 30'h0000_0005, 4'h3, 32'hCAFE_F00D, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[6]  = '{1'b0, 30'h0000_0005, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'h0000_F00D, 32'h0000_0000, 1'b0};
      vecs[7]  = '{1'b1, 30'h0000_03FF, 4'hF, 32'h5A5A_5A5A, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[8]  = '{1'b0, 30'h0000_03FF, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0};
      vecs[9]  = '{1'b1, 30'h3FFF_FC01, 4'hF, 32'h0000_00A5, 32'h0000_0000, 32'h0000_0000, 32'h0000_00A5, 1'b0};
      vecs[10] = '{1'b1, 30'h3FFF_FC01, 4'h2, 32'hFFFF_FF77, 32'h0000_0000, 32'h0000_0000, 32'h0000_FFA5, 1'b0};
      vecs[11] = '{1'b0, 30'h3FFF_FC01, 4'hF, 32'h0000_0000, 32'h0000_55AA, 32'h0000_FFA5, 32'h0000_FFA5, 1'b0};
      vecs[12] = '{1'b0, 30'h3FFF_FC02, 4'hF, 32'h0000_0000, 32'h0000_1234, 32'h0000_1234, 32'h0000_FFA5, 1'b0};
      vecs[13] = '{1'b0, 30'h3FFF_FC03, 4'hF, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 32'h0000_FFA5, 1'b0};
      vecs[14] = '{1'b1, 30'h3FFF_FC02, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_FFA5, 1'b0};
      vecs[15] = '{1'b0, 30'h0000_0400, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_FFA5, 1'b1};
      vecs[16] = '{1'b0, 30'h2000_0000, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_FFA5, 1'b1};
      vecs[17] = '{1'b0, 30'h3FFF_FC04, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_FFA5, 1'b1};
      vecs[18] = '{1'b1, 30'h2000_0004, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_FFA5, 1'b1};
      vecs[19] = '{1'b0, 30'h0000_0004, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'hDE11_BEEF, 32'h0000_FFA5, 1'b1};

      for (int i = 0; i < 3; i++) begin
         rst_a[i] = 1'b1; mem_a[i] = 1'b0; we_a[i] = 1'b0;
         addr_a[i] = '0; sel_a[i] = '0; wdata_a[i] = '0;
      end
      gpio_in = '0;

      // ---------------------------------------------------- reset state
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset ack",   32'(ack_a[0]),   32'd0);
      chk("reset rdata", rdata_a[0],      32'd0);
      chk("reset gpio",  gpio_a[0],       32'd0);
      chk("reset fault", 32'(fault_a[0]), 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;

      // ------------------------------------- table vectors, WAIT_STATES=0
      // Vector 0 starts in the first cycle out of reset: counter reads 0.
      for (int i = 0; i < NV; i++) begin
         gpio_in = vecs[i].gin;
         access(0, 0, vecs[i].wr, vecs[i].addr, vecs[i].sel, vecs[i].wdata, rd, gp, ft);
         if (!vecs[i].wr) chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("v%0d gpio_out", i), gp, vecs[i].exp_gpio);
         chk($sformatf("v%0d fault", i), 32'(ft), 32'(vecs[i].exp_fault));
      end

      // ------------------------------------------------- cycle counter
      access(0, 0, 1'b0, 30'h3FFF_FC00, 4'hF, 32'h0, c1, gp, ft);
      repeat (4) @(posedge clk);
      #1;
      access(0, 0, 1'b0, 30'h3FFF_FC00, 4'hF, 32'h0, c2, gp, ft);
      chk("counter delta 7", c2 - c1, 32'd7);
      access(0, 0, 1'b1, 30'h3FFF_FC00, 4'hF, 32'h0, rd, gp, ft);
      access(0, 0, 1'b0, 30'h3FFF_FC00, 4'hF, 32'h0, c3, gp, ft);
      chk("counter ignores store", c3 - c2, 32'd6);

      // ------------------------------ fault held until rst; RAM survives
      chk("fault sticky", 32'(fault_a[0]), 32'd1);
      rst_a[0] = 1'b1;
      @(negedge clk);
      chk("rst ack low",    32'(ack_a[0]),   32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst clears fault", 32'(fault_a[0]), 32'd0);
      chk("rst clears rdata", rdata_a[0],      32'd0);
      chk("rst clears gpio",  gpio_a[0],       32'd0);
      @(posedge clk); #1;
      rst_a[0] = 1'b0;
      access(0, 0, 1'b0, 30'h0000_0004, 4'hF, 32'h0, rd, gp, ft);
      chk("RAM kept over rst", rd, 32'hDE11_BEEF);
      chk("fault after rst", 32'(ft), 32'd0);

      // --------------------------------------------- WAIT_STATES=3
      access(1, 3, 1'b1, 30'h0000_0002, 4'hF, 32'h0102_0304, rd, gp, ft);
      // Back-to-back loads with mem held: acks 4 and 9 cycles after first seen.
      mem_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 30'h0000_0002; sel_a[1] = 4'hF;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk($sformatf("ws3 held ack k=%0d", k), 32'(ack_a[1]), 32'((k == 4) || (k == 9)));
         if (ack_a[1]) chk($sformatf("ws3 held rdata k=%0d", k), rdata_a[1], 32'h0102_0304);
         @(posedge clk); #1;
         if (k == 9) mem_a[1] = 1'b0;
      end
      $display("[TB] dut1 held-mem load pair done");
      // mem dropped during WAIT: the latched load still completes once.
      mem_a[1] = 1'b1;
      @(posedge clk); #1;
      mem_a[1] = 1'b0;
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("ws3 drop ack k=%0d", k), 32'(ack_a[1]), 32'(k == 4));
         if (ack_a[1]) chk("ws3 drop rdata", rdata_a[1], 32'h0102_0304);
         @(posedge clk); #1;
      end
      $display("[TB] dut1 load with mem dropped in WAIT done");

      // --------------------------------------------- WAIT_STATES=2
      access(2, 2, 1'b1, 30'h0000_0007, 4'hF, 32'hAAAA_5555, rd, gp, ft);
      // rst during WAIT of a store: no ack, store dropped.
      mem_a[2] = 1'b1; we_a[2] = 1'b1; addr_a[2] = 30'h0000_0007; wdata_a[2] = 32'h1234_5678;
      @(posedge clk); #1;
      rst_a[2] = 1'b1; mem_a[2] = 1'b0;
      for (int k = 1; k < 7; k++) begin
         @(negedge clk);
         chk($sformatf("ws2 wait-rst ack k=%0d", k), 32'(ack_a[2]), 32'd0);
         @(posedge clk); #1;
         if (k == 2) rst_a[2] = 1'b0;
      end
      $display("[TB] dut2 store aborted by rst in WAIT");
      access(2, 2, 1'b0, 30'h0000_0007, 4'hF, 32'h0, rd, gp, ft);
      chk("ws2 dropped store", rd, 32'hAAAA_5555);

      // rst in the ACK cycle: ack forced low, committed store stays.
      mem_a[2] = 1'b1; we_a[2] = 1'b1; addr_a[2] = 30'h0000_0007; wdata_a[2] = 32'h0BAD_0BAD;
      repeat (3) @(posedge clk);
      #1;
      rst_a[2] = 1'b1; mem_a[2] = 1'b0;
      @(negedge clk);
      chk("ws2 ack-rst ack", 32'(ack_a[2]), 32'd0);
      @(posedge clk); #1;
      rst_a[2] = 1'b0;
      $display("[TB] dut2 store with rst in ACK");
      access(2, 2, 1'b0, 30'h0000_0007, 4'hF, 32'h0, rd, gp, ft);
      chk("ws2 committed store", rd, 32'h0BAD_0BAD);

      // rst with mem in IDLE: nothing latched.
      rst_a[2] = 1'b1; mem_a[2] = 1'b1; we_a[2] = 1'b1; wdata_a[2] = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      rst_a[2] = 1'b0; mem_a[2] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("ws2 idle-rst ack k=%0d", k), 32'(ack_a[2]), 32'd0);
         @(posedge clk); #1;
      end
      $display("[TB] dut2 request under rst ignored");
      access(2, 2, 1'b0, 30'h0000_0007, 4'hF, 32'h0, rd, gp, ft);
      chk("ws2 idle-rst no store", rd, 32'h0BAD_0BAD);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
